// File: rtl/iir_mac_sequencer.sv
// Time-multiplexed 2nd-order IIR: one shared multiply-accumulate unit sequenced
// over five cycles, y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2 (mod 2^ACC_W).
module iir_mac_sequencer #(
   parameter int X_W   = 4,
   parameter int C_W   = 4,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [X_W-1:0]   in_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_y,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [C_W-1:0]   cfg_data,
   input  logic             clr_hist,
   output logic             busy
);

   localparam int P_W = C_W + ACC_W;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t             state;
   state_t             state_nx;
   logic [2:0]         step;
   logic [X_W-1:0]     x_q;
   logic [X_W-1:0]     x1;
   logic [X_W-1:0]     x2;
   logic [ACC_W-1:0]   y1;
   logic [ACC_W-1:0]   y2;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_nx;
   logic [C_W-1:0]     b0, b1, b2, a1, a2;
   logic [C_W-1:0]     coef_sel;
   logic [ACC_W-1:0]   opnd_sel;
   logic [P_W-1:0]     prod;
   logic               accept;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and out_valid/out_y hold until the transfer.
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   // Operand mux for the shared multiplier, indexed by the MAC step.
   always_comb begin
      coef_sel = b0;
      opnd_sel = ACC_W'(x_q);
      case (step)
         3'd1: begin
            coef_sel = b1;
            opnd_sel = ACC_W'(x1);
         end
         3'd2: begin
            coef_sel = b2;
            opnd_sel = ACC_W'(x2);
         end
         3'd3: begin
            coef_sel = a1;
            opnd_sel = y1;
         end
         3'd4: begin
            coef_sel = a2;
            opnd_sel = y2;
         end
         default: ;
      endcase
      prod   = P_W'(coef_sel) * P_W'(opnd_sel);
      acc_nx = acc + prod[ACC_W-1:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = MAC;
         MAC:     if (step == 3'd4) state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         step      <= '0;
         acc       <= '0;
         x_q       <= '0;
         x1        <= '0;
         x2        <= '0;
         y1        <= '0;
         y2        <= '0;
         out_y     <= '0;
         out_valid <= 1'b0;
         b0        <= C_W'(1);
         b1        <= C_W'(1);
         b2        <= C_W'(1);
         a1        <= C_W'(14);
         a2        <= C_W'(14);
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               // Coefficients and history only change between samples.
               if (cfg_we) begin
                  case (cfg_addr)
                     3'd0:    b0 <= cfg_data;
                     3'd1:    b1 <= cfg_data;
                     3'd2:    b2 <= cfg_data;
                     3'd3:    a1 <= cfg_data;
                     3'd4:    a2 <= cfg_data;
                     default: ;
                  endcase
               end
               if (clr_hist) begin
                  x1 <= '0;
                  x2 <= '0;
                  y1 <= '0;
                  y2 <= '0;
               end
               if (accept) begin
                  x_q  <= in_x;
                  acc  <= '0;
                  step <= '0;
               end
            end
            MAC: begin
               acc  <= acc_nx;
               step <= step + 3'd1;
               if (step == 3'd4) begin
                  step      <= '0;
                  x2        <= x1;
                  x1        <= x_q;
                  y2        <= y1;
                  y1        <= acc_nx;
                  out_y     <= acc_nx;
                  out_valid <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/iir_mac_sequencer.md
Name: iir_mac_sequencer

Overview:
Time-multiplexed controller for the 2nd-order IIR filter datapath (y = b0·x + b1·x1 + b2·x2 + a1·y1 + a2·y2). It replaces five parallel multipliers with one shared multiply-accumulate unit and sequences the five products over five cycles with an FSM. It sits between an upstream sample source and a downstream consumer, using valid/ready handshakes on both sides. A register write port holds the five coefficients.

Parameters:
X_W, 4, input sample width (unsigned)
C_W, 4, coefficient width (unsigned)
ACC_W, 12, accumulator, output and y-history width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  sample x offered
in_ready  output  1  block can accept a sample
in_x  input  X_W  input sample
out_valid  output  1  result y available
out_ready  input  1  downstream accepts y
out_y  output  ACC_W  filter output
cfg_we  input  1  coefficient write strobe
cfg_addr  input  3  0=b0 1=b1 2=b2 3=a1 4=a2; 5-7 reserved
cfg_data  input  C_W  coefficient value
clr_hist  input  1  clear x1, x2, y1, y2
busy  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: reset is rst, synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values:
  - FSM=IDLE; in_ready=1; out_valid=0; out_y=0; busy=0.
  - acc=0; step=0; x1=x2=y1=y2=0.
  - b0=b1=b2=1; a1=a2=4'd14.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch x=in_x, acc=0, step=0, go to MAC.
- MAC (exactly 5 cycles, step 0..4):
  - Each cycle computes acc <= acc + coef[step]*opnd[step], truncated modulo 2^ACC_W.
  - Operand order: step 0 b0·x, step 1 b1·x1, step 2 b2·x2, step 3 a1·y1, step 4 a2·y2.
  - Operands are zero-extended. Product width is C_W+ACC_W, truncated to ACC_W before the add.
  - On step 4 the registered result is r = final acc value. In the same edge, go to OUT and update history: x2<=x1, x1<=x, y2<=y1, y1<=r.
  - Set out_y<=r and out_valid<=1.
- OUT:
  - out_valid=1; out_y stable until handshake.
  - On out_ready: out_valid<=0 and go to IDLE.
  - in_ready=0 here, so there is no overlap of samples.
- Latency and throughput:
  - Input accept at cycle 0; out_valid rises at cycle 6.
  - Best-case throughput is 1 sample per 7 cycles when out_ready is held high.
- in_ready: asserted only in IDLE. busy = (state != IDLE).
- Coefficient writes:
  - Applied only when state==IDLE and cfg_addr<=4.
  - Writes while busy, or to addresses 5-7, are silently dropped.
  - A write in the same cycle as a sample accept takes effect for that sample.
- clr_hist:
  - Honoured only in IDLE: zeroes x1, x2, y1, y2 next edge. Ignored when busy.
  - If asserted with an accept in the same cycle, the history is cleared before step 1 uses x1.
  - Equivalently, the sample computes with zero history.
- Overflow: all arithmetic wraps modulo 2^ACC_W. No saturation and no flag.
- Reset mid-operation: rst in MAC or OUT aborts immediately. The partial result is discarded, outputs return to reset values, and coefficients revert to defaults.
- in_x is only sampled on the accept edge. Changes to in_x at other times have no effect.

Test Plan:
- Impulse with default coefficients, out_ready=1: samples x=1,0,0 -> out_y=1, 15, 225. Each out_valid arrives 6 cycles after its accept, with accepts spaced 7 cycles apart.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_y stay stable and in_ready stays 0. Release -> IDLE next cycle and in_ready=1.
- Config: write b0=3 and a1=0 in IDLE, then send x=5 from cleared history -> out_y=15. Attempt a write of b0=7 during MAC -> ignored, and next x=1 gives b0 term 3.
- Wrap-around: set all coefficients to 15 and drive x=15 repeatedly -> each out_y matches the modulo-4096 reference model. No X values appear.
- Reset mid-MAC: assert rst at step 2 -> next cycle out_valid=0, in_ready=1, coefficients at defaults. Then x=1 -> out_y=1.
- clr_hist with simultaneous accept after prior nonzero history: x=2 -> out_y=2, with history terms zero.
